seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter: BLANK_CYCLES, default 4, anti-ghosting blank interval in clk cycles after each digit change; legal range 0..255.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 tick  input  1  one-cycle digit-advance enable from the time base's sevenSeg output (20 kHz).
REQ-005 value  input  16  four hex nibbles; nibble 0 = rightmost digit, nibble 3 = leftmost digit.
REQ-006 dp_in  input  4  decimal-point request per digit; bit i = digit i.
REQ-007 load  input  1  capture value/dp_in into the pending register this cycle.
REQ-008 an  output  4  digit anodes, active-low.
REQ-009 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal-point cathode, active-low.
REQ-011 frame_start  output  1  one-cycle pulse when digit index wraps 3->0.

Function
REQ-012 States: IDLE, BLANK, DRIVE; a 2-bit digit index idx; an 8-bit blank counter.
REQ-013 IDLE: an=1111, seg=1111111, dp=1; on tick -> idx advance (REQ-015), then BLANK, or DRIVE if BLANK_CYCLES=0.
REQ-014 DRIVE: on tick -> idx advance (REQ-015), then BLANK with counter=BLANK_CYCLES-1, or stay in DRIVE with the new idx if BLANK_CYCLES=0.
REQ-015 idx advance: idx <= idx+1 mod 4; the first tick after reset selects digit 0.
REQ-016 BLANK: an=1111; counter decrements each cycle; at counter=0 -> DRIVE next cycle; BLANK therefore lasts exactly BLANK_CYCLES cycles.
REQ-017 A tick arriving in BLANK is ignored: no idx advance, counter not reloaded.
REQ-018 DRIVE outputs: an bit idx=0, others=1; seg=hex decode of display nibble idx; dp=~display_dp[idx].
REQ-019 an/seg/dp are registers whose value in any cycle reflects that cycle's state and idx; no combinational path from inputs.
REQ-020 Hex decode (active-low {g..a}): 0=1000000, 1=1111001, 4=0011001, 5=0010010, 8=0000000, A=0001000, F=0001110; the remaining codes follow the standard hex glyph set.
REQ-021 Pending register: on load, pending <= {value, dp_in}; a later load overwrites it.
REQ-022 Display register updates only on a wrap 3->0 (tear-free): display <= load ? {value, dp_in} : pending; a load in the same cycle as the wrap wins.
REQ-023 frame_start is high for exactly the one cycle following the edge at which a wrapping tick was accepted; it is low otherwise, including for ticks ignored under REQ-017.

Reset
REQ-024 Reset forces: state=IDLE, idx=3, counter=0, pending=0, display=0, an=1111, seg=1111111, dp=1, frame_start=0.
REQ-025 Reset overrides tick and load in the same cycle; reset asserted mid-BLANK or mid-DRIVE behaves identically to reset from any other state.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN defined: in DRIVE, digit i>0 shows seg=1111111 (anode still driven) when display nibbles i..3 are all zero; digit 0 is always decoded; dp is unaffected.
REQ-027 Macro LEADING_ZERO_BLANK_EN undefined: every digit is decoded per REQ-020.

Verification
REQ-028 Reset, then 100 cycles without tick -> an=1111, seg=1111111, dp=1, frame_start=0 throughout.
REQ-029 load value=0x1234, then first tick (BLANK_CYCLES=4) -> frame_start=1 for one cycle; an=1111 for 4 cycles; then an=1110, seg=0011001.
REQ-030 Display 0x1234; load 0xABCD while idx=1 -> digits 2 and 3 still show 2 and 1; after the next wrap, digit 0 shows D, digit 3 shows A.
REQ-031 load 0x8888 in the same cycle as the wrapping tick -> digit 0 in that frame shows seg=0000000.
REQ-032 Tick during BLANK -> idx unchanged, BLANK length stays 4 cycles, no frame_start.
REQ-033 value=0x0050, one full frame -> macro defined: digits 3 and 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000; macro undefined: digits 3 and 2 show 1000000.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit multiplexed seven-segment scanner, tear-free frames.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero digits.
module seven_seg_scan #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  localparam logic [7:0] BLANK_INIT =
    (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic [1:0]  idx;
  logic [1:0]  idx_n;
  logic [7:0]  cnt;
  logic [7:0]  cnt_n;
  logic [19:0] pend;
  logic [19:0] pend_n;
  logic [19:0] disp;
  logic [19:0] disp_n;
  logic        fs_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  nib;
  logic        lz;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next state, digit index, blank timer and frame registers
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    disp_n  = disp;
    fs_n    = 1'b0;
    pend_n  = load ? {value, dp_in} : pend;
    unique case (state)
      IDLE, DRIVE: begin
        if (tick) begin
          idx_n = idx + 2'd1;
          if (idx == 2'd3) begin
            fs_n   = 1'b1;
            disp_n = load ? {value, dp_in} : pend;
          end
          if (BLANK_CYCLES == 0) begin
            state_n = DRIVE;
          end else begin
            state_n = BLANK;
            cnt_n   = BLANK_INIT;
          end
        end
      end
      BLANK: begin
        if (cnt == 8'd0) begin
          state_n = DRIVE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output drive derived from next state so registers match their cycle
  always_comb begin
    an_n  = 4'b1111;
    seg_n = 7'b1111111;
    dp_n  = 1'b1;
    lz    = 1'b0;
    unique case (idx_n)
      2'd0: nib = disp_n[7:4];
      2'd1: nib = disp_n[11:8];
      2'd2: nib = disp_n[15:12];
      default: nib = disp_n[19:16];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    unique case (idx_n)
      2'd1: lz = (disp_n[19:8] == 12'd0);
      2'd2: lz = (disp_n[19:12] == 8'd0);
      2'd3: lz = (disp_n[19:16] == 4'd0);
      default: lz = 1'b0;
    endcase
`endif
    if (state_n == DRIVE) begin
      unique case (idx_n)
        2'd0: an_n = 4'b1110;
        2'd1: an_n = 4'b1101;
        2'd2: an_n = 4'b1011;
        default: an_n = 4'b0111;
      endcase
      seg_n = lz ? 7'b1111111 : hex7(nib);
      dp_n  = ~disp_n[idx_n];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 2'd3;
      cnt         <= 8'd0;
      pend        <= 20'd0;
      disp        <= 20'd0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      pend        <= pend_n;
      disp        <= disp_n;
      an          <= an_n;
      seg         <= seg_n;
      dp          <= dp_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench for seven_seg_scan.
// Expected outputs queued per driven cycle, popped after the edge.
module tb_seven_seg_scan;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  logic [12:0] sbq [$];

  logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
  };
  logic [3:0] AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int          m_st;
  logic [1:0]  m_idx;
  int          m_left;
  logic [19:0] m_pend;
  logic [15:0] m_val;
  logic [3:0]  m_dpr;
  logic        m_fs;

  seven_seg_scan #(.BLANK_CYCLES(BC)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .value(value),
    .dp_in(dp_in),
    .load(load),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic m_step(input logic r, input logic t, input logic ld,
                        input logic [15:0] v, input logic [3:0] d);
    logic [3:0]  nib;
    logic [12:0] e;
    if (r) begin
      m_st = 0; m_idx = 2'd3; m_left = 0;
      m_pend = '0; m_val = '0; m_dpr = '0; m_fs = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (t && m_st != 1) begin
        if (m_idx == 2'd3) begin
          m_fs = 1'b1;
          {m_val, m_dpr} = ld ? {v, d} : m_pend;
        end
        m_idx = m_idx + 2'd1;
        if (BC == 0) m_st = 2;
        else begin
          m_st = 1;
          m_left = BC;
        end
      end else if (m_st == 1) begin
        m_left--;
        if (m_left == 0) m_st = 2;
      end
      if (ld) m_pend = {v, d};
    end
    e = {4'hf, 7'h7f, 1'b1, m_fs};
    if (m_st == 2) begin
      nib = 4'(m_val >> (4 * m_idx));
      e[12:9] = AN[m_idx];
      e[8:2]  = GLYPH[nib];
      e[1]    = ~m_dpr[m_idx];
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx != 2'd0 && (m_val >> (4 * m_idx)) == 16'd0)
        e[8:2] = 7'h7f;
`endif
    end
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic t, input logic ld,
                     input logic [15:0] v, input logic [3:0] d);
    logic [12:0] e;
    reset = r; tick = t; load = ld; value = v; dp_in = d;
    m_step(r, t, ld, v, d);
    @(posedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    chk("cyc", {19'd0, an, seg, dp, frame_start}, {19'd0, e});
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic tk();
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic adv();
    tk();
    repeat (BC) idle();
  endtask

  task automatic chk_rst(input string tag);
    chk(tag, {an, seg, dp, frame_start}, {4'hf, 7'h7f, 1'b1, 1'b0});
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    cyc(1'b1, 1'b1, 1'b1, 16'hffff, 4'hf);
    chk_rst("rst");
    repeat (100) idle();
    chk_rst("idle100");

    cyc(1'b0, 1'b0, 1'b1, 16'h1234, 4'h0);
    tk();
    chk("r29_fs", frame_start, 1);
    chk("r29_an_b0", an, 4'hf);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("r29_blank", an, 4'hf);
      chk("r29_fs0", frame_start, 0);
    end
    idle();
    chk("r29_an", an, 4'b1110);
    chk("r29_seg", seg, 7'b0011001);

    adv();
    cyc(1'b0, 1'b0, 1'b1, 16'habcd, 4'b0010);
    chk("r30_d1", seg, 7'b0110000);
    adv();
    chk("r30_an2", an, 4'b1011);
    chk("r30_d2", seg, 7'b0100100);
    adv();
    chk("r30_an3", an, 4'b0111);
    chk("r30_d3", seg, 7'b1111001);
    adv();
    chk("r30_new0", seg, 7'b0100001);
    adv();
    chk("r30_dp1", dp, 0);
    adv();
    adv();
    chk("r30_new3", seg, 7'b0001000);

    cyc(1'b0, 1'b1, 1'b1, 16'h8888, 4'h0);
    chk("r31_fs", frame_start, 1);
    idle();
    chk("r32_b2", an, 4'hf);
    tk();
    chk("r32_fs", frame_start, 0);
    chk("r32_b3", an, 4'hf);
    idle();
    chk("r32_b4", an, 4'hf);
    idle();
    chk("r32_an", an, 4'b1110);
    chk("r31_seg", seg, 7'b0000000);

    cyc(1'b0, 1'b0, 1'b1, 16'h0050, 4'h0);
    adv(); adv(); adv();
    chk("r33_old3", seg, 7'b0000000);
    adv();
    chk("r33_d0", seg, 7'b1000000);
    adv();
    chk("r33_d1", seg, 7'b0010010);
    adv();
`ifdef LEADING_ZERO_BLANK_EN
    chk("r33_d2", seg, 7'b1111111);
    chk("r33_an2", an, 4'b1011);
`else
    chk("r33_d2", seg, 7'b1000000);
`endif
    adv();
`ifdef LEADING_ZERO_BLANK_EN
    chk("r33_d3", seg, 7'b1111111);
`else
    chk("r33_d3", seg, 7'b1000000);
`endif

    tk();
    idle();
    cyc(1'b1, 1'b1, 1'b1, 16'h5555, 4'hf);
    chk_rst("rst_blank");
    tk();
    chk("rst_fs", frame_start, 1);
    repeat (BC) idle();
    chk("rst_d0", seg, 7'b1000000);
    chk("rst_an0", an, 4'b1110);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    chk_rst("rst_drive");

    repeat (400)
      cyc(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          16'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
